// File: rtl/sdram_bram_responder.sv
// Block-RAM stand-in for the SDRAM controller behind the arbiter.
// It accepts single-word writes and single or burst reads, and returns tagged read data after a fixed latency.
module sdram_bram_responder #(
    parameter int ADDR_WIDTH   = 14,
    parameter int BURST_LEN    = 16,
    parameter int READ_LATENCY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  sdram_req,
    input  logic [25:0] sdram_addr,
    input  logic        sdram_write,
    input  logic        sdram_burst,
    input  logic [3:0]  sdram_byte_enable,
    input  logic [31:0] sdram_wdata,
    output logic        sdram_ack,
    output logic [31:0] sdram_rdata,
    output logic [2:0]  sdram_rdvalid,
    output logic        sdram_complete
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_READ,
        ST_DRAIN,
        ST_GAP
    } state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              tag_reg;
    logic [ADDR_WIDTH-1:0]   word_reg;
    logic                    write_reg;
    logic                    burst_reg;
    logic [3:0]              be_reg;
    logic [31:0]             wdata_reg;
    logic [BEAT_W-1:0]       beat_reg;

    logic                    issue;
    logic                    issue_last;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   rd_word;
    logic [31:0]             ram_q;
    logic [31:0]             rd_data;

    logic [2:0]              tag_pipe  [READ_LATENCY];
    logic                    last_pipe [READ_LATENCY];

    // Address bits outside the word index are ignored, so higher addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sdram_addr[1:0], sdram_addr[25:ADDR_WIDTH+2]};

    // Bursts walk upward one word per beat and wrap at the top of the RAM.
    assign rd_word = word_reg + ADDR_WIDTH'(beat_reg);

    always_comb begin
        state_next = state_reg;
        sdram_ack  = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (sdram_req != 3'd0) begin
                    state_next = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                sdram_ack = 1'b1;
                if (write_reg) begin
                    wr_en      = 1'b1;
                    state_next = ST_GAP;
                end else begin
                    issue      = 1'b1;
                    issue_last = !burst_reg || (BURST_LEN == 1);
                    state_next = (burst_reg && (BURST_LEN > 1)) ? ST_READ : ST_DRAIN;
                end
            end
            ST_READ: begin
                issue = 1'b1;
                if (beat_reg == BEAT_W'(BURST_LEN - 1)) begin
                    issue_last = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_pipe[READ_LATENCY-1]) begin
                    state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            beat_reg  <= '0;
            tag_reg   <= '0;
            word_reg  <= '0;
            write_reg <= 1'b0;
            burst_reg <= 1'b0;
            be_reg    <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= issue ? beat_reg + BEAT_W'(1) : '0;
            if (state_reg == ST_IDLE && sdram_req != 3'd0) begin
                tag_reg   <= sdram_req;
                word_reg  <= sdram_addr[ADDR_WIDTH+1:2];
                write_reg <= sdram_write;
                burst_reg <= sdram_burst;
                be_reg    <= sdram_byte_enable;
                wdata_reg <= sdram_wdata;
            end
        end
    end

    // One RAM per byte lane keeps partial writes simple while still mapping to block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q;

            always_ff @(posedge clock) begin
                if (wr_en && be_reg[gi]) begin
                    mem[word_reg] <= wdata_reg[8*gi +: 8];
                end
                if (issue) begin
                    q <= mem[rd_word];
                end
            end

            assign ram_q[8*gi +: 8] = q;
        end
    endgenerate

    // The RAM register is the first latency stage; data only needs the remaining delay.
    generate
        if (READ_LATENCY == 1) begin : g_no_delay
            assign rd_data = ram_q;
        end else begin : g_delay
            logic [31:0] data_dly [READ_LATENCY-1];

            always_ff @(posedge clock) begin
                data_dly[0] <= ram_q;
                for (int i = 1; i < READ_LATENCY - 1; i++) begin
                    data_dly[i] <= data_dly[i-1];
                end
            end

            assign rd_data = data_dly[READ_LATENCY-2];
        end
    endgenerate

    // The tag and last-beat flags travel alongside the data; clearing them flushes in-flight beats.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe[i]  <= '0;
                last_pipe[i] <= 1'b0;
            end
        end else begin
            tag_pipe[0]  <= issue ? tag_reg : 3'd0;
            last_pipe[0] <= issue && issue_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe[i]  <= tag_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    assign sdram_rdvalid  = tag_pipe[READ_LATENCY-1];
    assign sdram_complete = last_pipe[READ_LATENCY-1];
    assign sdram_rdata    = (tag_pipe[READ_LATENCY-1] != 3'd0) ? rd_data : 32'd0;

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Directed and randomized checks of sdram_bram_responder against a word-array model.
module tb_sdram_bram_responder;

    localparam int WORDS = 16384;
    localparam int BLEN  = 16;
    localparam int LAT   = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  sdram_req;
    logic [25:0] sdram_addr;
    logic        sdram_write;
    logic        sdram_burst;
    logic [3:0]  sdram_byte_enable;
    logic [31:0] sdram_wdata;
    logic        sdram_ack;
    logic [31:0] sdram_rdata;
    logic [2:0]  sdram_rdvalid;
    logic        sdram_complete;

    int checks = 0;
    int fails  = 0;
    logic [31:0] model [WORDS];

    always #5 clock = ~clock;

    sdram_bram_responder #(
        .ADDR_WIDTH(14),
        .BURST_LEN(BLEN),
        .READ_LATENCY(LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sdram_req(sdram_req),
        .sdram_addr(sdram_addr),
        .sdram_write(sdram_write),
        .sdram_burst(sdram_burst),
        .sdram_byte_enable(sdram_byte_enable),
        .sdram_wdata(sdram_wdata),
        .sdram_ack(sdram_ack),
        .sdram_rdata(sdram_rdata),
        .sdram_rdvalid(sdram_rdvalid),
        .sdram_complete(sdram_complete)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int word_of(input logic [25:0] a);
        return int'(a[15:2]);
    endfunction

    function automatic logic [25:0] addr_of(input int w);
        logic [25:0] a;
        a = {10'($urandom), 14'(w), 2'($urandom)};
        return a;
    endfunction

    task automatic model_write(input int w, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) model[w][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic issue(input logic [2:0] tag, input logic [25:0] addr, input logic wr,
                         input logic burst, input logic [3:0] be, input logic [31:0] data);
        sdram_req         = tag;
        sdram_addr        = addr;
        sdram_write       = wr;
        sdram_burst       = burst;
        sdram_byte_enable = be;
        sdram_wdata       = data;
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (sdram_ack) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk("ack_timeout", {31'd0, sdram_ack}, 32'd1);
        sdram_req = 3'd0;
    endtask

    task automatic do_write(input logic [2:0] tag, input logic [25:0] addr,
                            input logic [3:0] be, input logic [31:0] data);
        int lat;
        issue(tag, addr, 1'b1, 1'b0, be, data);
        wait_ack(lat);
        chk("wr_ack_latency", lat, 1);
        model_write(word_of(addr), be, data);
        step();
        chk("wr_ack_pulse", {31'd0, sdram_ack}, 32'd0);
        step();
        $display("write tag=%0d word=%h be=%b data=%h", tag, word_of(addr), be, data);
    endtask

    // Watches beats of an accepted read, starting in the cycle after its ack.
    task automatic collect(input logic [2:0] tag, input int base, input int n, input int upto);
        for (int c = 1; c < LAT; c++) begin
            step();
            chk("pre_beat_rdvalid", sdram_rdvalid, 0);
            chk("pre_beat_rdata", sdram_rdata, 0);
            chk("pre_beat_ack", {31'd0, sdram_ack}, 0);
        end
        for (int k = 0; k < upto; k++) begin
            step();
            chk("beat_rdvalid", sdram_rdvalid, tag);
            chk("beat_rdata", sdram_rdata, model[(base + k) % WORDS]);
            chk("beat_complete", {31'd0, sdram_complete}, (k == n - 1) ? 1 : 0);
            chk("beat_ack", {31'd0, sdram_ack}, 0);
        end
    endtask

    task automatic do_read(input logic [2:0] tag, input logic [25:0] addr, input logic burst);
        int lat;
        int n;
        n = burst ? BLEN : 1;
        issue(tag, addr, 1'b0, burst, 4'h0, 32'h0);
        wait_ack(lat);
        chk("rd_ack_latency", lat, 1);
        collect(tag, word_of(addr), n, n);
        step();
        chk("post_read_rdvalid", sdram_rdvalid, 0);
        $display("read tag=%0d word=%h burst=%0d", tag, word_of(addr), burst);
    endtask

    initial begin
        int lat;
        issue(3'd0, 26'd0, 1'b0, 1'b0, 4'h0, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
        step();
        step();
        step();
        chk("reset_ack", {31'd0, sdram_ack}, 0);
        chk("reset_rdvalid", sdram_rdvalid, 0);
        chk("reset_rdata", sdram_rdata, 0);
        chk("reset_complete", {31'd0, sdram_complete}, 0);
        reset = 1'b1;

        // Basic write then single read.
        do_write(3'd2, 26'h000100, 4'hF, 32'hDEADBEEF);
        do_read(3'd2, 26'h000100, 1'b0);

        // Partial-lane merge.
        do_write(3'd4, 26'h000040, 4'hF, 32'h11223344);
        do_write(3'd4, 26'h000040, 4'b0101, 32'hAABBCCDD);
        do_read(3'd4, 26'h000040, 1'b0);

        // Empty byte-enable leaves RAM untouched; aliased address reads the same word.
        do_write(3'd5, 26'h000100, 4'h0, 32'h12345678);
        do_read(3'd5, 26'h000100, 1'b0);
        do_read(3'd6, 26'h0010100, 1'b0);

        // Burst over indexed words.
        for (int i = 0; i < 32; i++) do_write(3'd1, 26'((32'h200 + i) << 2), 4'hF, i);
        do_read(3'd1, 26'h000800, 1'b1);

        // Burst wrapping from the top of the RAM.
        for (int i = 0; i < 16; i++) do_write(3'd7, addr_of((16'h3FF8 + i) % WORDS), 4'hF, $urandom);
        do_read(3'd1, 26'h00FFE0, 1'b1);

        // A held request waits for the burst to finish.
        issue(3'd1, 26'h000800, 1'b0, 1'b1, 4'h0, 32'h0);
        wait_ack(lat);
        chk("held_first_ack_latency", lat, 1);
        issue(3'd3, 26'h000100, 1'b0, 1'b0, 4'h0, 32'h0);
        collect(3'd1, 32'h200, BLEN, BLEN);
        wait_ack(lat);
        chk("held_ack_after_complete", lat, 2);
        collect(3'd3, 32'h40, 1, 1);
        step();
        chk("held_post_rdvalid", sdram_rdvalid, 0);
        $display("held read tag=3 acked %0d cycles after burst complete", lat);

        // Randomized mix of writes and reads in the indexed region.
        for (int t = 0; t < 40; t++) begin
            int w;
            if ($urandom_range(0, 1) == 1) begin
                w = 32'h200 + $urandom_range(0, 31);
                do_write(3'($urandom_range(1, 7)), addr_of(w), 4'($urandom), $urandom);
            end else if ($urandom_range(0, 2) == 0) begin
                w = 32'h200 + $urandom_range(0, 16);
                do_read(3'($urandom_range(1, 7)), addr_of(w), 1'b1);
            end else begin
                w = 32'h200 + $urandom_range(0, 31);
                do_read(3'($urandom_range(1, 7)), addr_of(w), 1'b0);
            end
        end

        // Reset in the middle of a burst abandons it.
        issue(3'd1, 26'h000800, 1'b0, 1'b1, 4'h0, 32'h0);
        wait_ack(lat);
        chk("rst_burst_ack_latency", lat, 1);
        collect(3'd1, 32'h200, BLEN, 6);
        reset = 1'b0;
        step();
        chk("midrst_rdvalid", sdram_rdvalid, 0);
        chk("midrst_ack", {31'd0, sdram_ack}, 0);
        chk("midrst_complete", {31'd0, sdram_complete}, 0);
        chk("midrst_rdata", sdram_rdata, 0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("after_rst_no_beats", {28'd0, sdram_complete, sdram_rdvalid}, 0);
        end
        $display("reset during burst beat 5, pipeline flushed");
        do_read(3'd2, 26'h000100, 1'b0);
        do_read(3'd2, 26'h000040, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
